// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: state encoding,
// queue entry layout and reset/step values for the program counter.
package fetch_pkg;

   localparam int DATA_WIDTH = 32;
   localparam logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000;
   localparam logic [DATA_WIDTH-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      F_RUN,
      F_WAIT,
      F_DISCARD
   } fetch_state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] instr;
      logic [DATA_WIDTH-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory, decode and redirect signals; the fetch
// unit takes the master side, memory/decode/branch logic the slave side.
interface fetch_unit_if;
   import fetch_pkg::*;

   logic                  PCsrc;
   logic [DATA_WIDTH-1:0] ImmOp;
   logic [DATA_WIDTH-1:0] branch_pc;
   logic                  imem_req_valid;
   logic                  imem_req_ready;
   logic [DATA_WIDTH-1:0] imem_addr;
   logic                  imem_rsp_valid;
   logic [DATA_WIDTH-1:0] imem_rsp_data;
   logic                  instr_valid;
   logic                  instr_ready;
   logic [DATA_WIDTH-1:0] instruction;
   logic [DATA_WIDTH-1:0] instr_pc;

   modport master (
      input  PCsrc, ImmOp, branch_pc,
      output imem_req_valid, imem_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output instr_valid, instruction, instr_pc,
      input  instr_ready
   );

   modport slave (
      output PCsrc, ImmOp, branch_pc,
      input  imem_req_valid, imem_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  instr_valid, instruction, instr_pc,
      output instr_ready
   );

endinterface

// File: rtl/fetch_fifo2.sv
// Two-entry in-order queue of fetched {instruction, pc} pairs; entry 0 is
// always the head, so a pop shifts entry 1 down.
module fetch_fifo2
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  fetch_entry_t pushData_i,
   output fetch_entry_t head_o,
   output logic [1:0]   count_o
);

   fetch_entry_t headEntry_q;
   fetch_entry_t tailEntry_q;
   logic [1:0]   count_q;

   // Flush only clears the count; stale entry contents are never observed
   // because the head is qualified by count.
   always_ff @(posedge clk) begin
      if (rst) begin
         headEntry_q <= '0;
         tailEntry_q <= '0;
         count_q     <= 2'd0;
      end else if (flush_i) begin
         count_q <= 2'd0;
      end else if (push_i && pop_i) begin
         if (count_q == 2'd2) begin
            headEntry_q <= tailEntry_q;
            tailEntry_q <= pushData_i;
         end else begin
            headEntry_q <= pushData_i;
         end
      end else if (push_i && (count_q != 2'd2)) begin
         if (count_q == 2'd0) begin
            headEntry_q <= pushData_i;
         end else begin
            tailEntry_q <= pushData_i;
         end
         count_q <= count_q + 2'd1;
      end else if (pop_i && (count_q != 2'd0)) begin
         headEntry_q <= tailEntry_q;
         count_q     <= count_q - 2'd1;
      end
   end

   assign head_o  = headEntry_q;
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one memory request in
// flight, queues responses for decode and redirects on taken branches.
module fetch_unit
   import fetch_pkg::*;
(
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);

   fetch_state_t          state_q;
   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] reqPc_q;
   logic [DATA_WIDTH-1:0] pc_d;
   logic [DATA_WIDTH-1:0] redirectPc;
   logic [1:0]            queueCount;
   fetch_entry_t          queueHead;
   fetch_entry_t          pushEntry;
   logic                  reqValid;
   logic                  reqAccept;
   logic                  rspKeep;
   logic                  popFire;

   // A redirect blocks issue in its own cycle so the old PC is never fetched.
   assign reqValid   = !rst && (state_q == F_RUN) && (queueCount != 2'd2) && !bus.PCsrc;
   assign reqAccept  = reqValid && bus.imem_req_ready;
   assign rspKeep    = bus.imem_rsp_valid && (state_q == F_WAIT) && !bus.PCsrc;
   assign popFire    = bus.instr_valid && bus.instr_ready && !bus.PCsrc;
   assign redirectPc = bus.branch_pc + bus.ImmOp;
   assign pushEntry  = '{instr: bus.imem_rsp_data, pc: reqPc_q};

   always_comb begin
      pc_d = pc_q;
      if (bus.PCsrc) begin
         pc_d = redirectPc;
      end else if (reqAccept) begin
         pc_d = pc_q + PC_STEP;
      end
   end

   // A redirect with a request still in flight marks that response for dropping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= F_RUN;
         pc_q    <= RESET_PC;
         reqPc_q <= '0;
      end else begin
         pc_q <= pc_d;
         if (reqAccept) begin
            reqPc_q <= pc_q;
         end
         unique case (state_q)
            F_RUN: begin
               if (reqAccept) begin
                  state_q <= F_WAIT;
               end
            end
            F_WAIT: begin
               if (bus.imem_rsp_valid) begin
                  state_q <= F_RUN;
               end else if (bus.PCsrc) begin
                  state_q <= F_DISCARD;
               end
            end
            F_DISCARD: begin
               if (bus.imem_rsp_valid) begin
                  state_q <= F_RUN;
               end
            end
            default: state_q <= F_RUN;
         endcase
      end
   end

   fetch_fifo2 u_queue (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (bus.PCsrc),
      .push_i     (rspKeep),
      .pop_i      (popFire),
      .pushData_i (pushEntry),
      .head_o     (queueHead),
      .count_o    (queueCount)
   );

   assign bus.imem_req_valid = reqValid;
   assign bus.imem_addr      = pc_q;
   assign bus.instr_valid    = (queueCount != 2'd0);
   assign bus.instruction    = queueHead.instr;
   assign bus.instr_pc       = queueHead.pc;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the decode/sign-extend stage. It owns the program counter and issues word fetches to instruction memory over a valid/ready request port with a variable-latency response. It buffers returned instructions with their PCs in a 2-entry queue for the decode consumer. It also redirects on taken branches using the sign-extended immediate (ImmOp) produced downstream.

Parameters:
DATA_WIDTH, 32, instruction and address width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
PCsrc  in  1  taken-branch redirect this cycle
ImmOp  in  DATA_WIDTH  sign-extended branch offset from the sign-extend stage
branch_pc  in  DATA_WIDTH  PC of the branching instruction
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  DATA_WIDTH  fetch address
imem_rsp_valid  in  1  response data valid (at most one per accepted request)
imem_rsp_data  in  DATA_WIDTH  fetched instruction word
instr_valid  out  1  queue head valid to decode
instr_ready  in  1  decode consumes head
instruction  out  DATA_WIDTH  head instruction
instr_pc  out  DATA_WIDTH  PC of head instruction

Behaviour:
- Reset (rst high at clk edge): pc=RESET_PC, queue count=0, state=F_RUN, req_pc=0. While rst is high, imem_req_valid=0. After reset: instr_valid=0, instruction=0, instr_pc=0.
- States:
  - F_RUN: no request outstanding.
  - F_WAIT: one request outstanding, response to be kept.
  - F_DISCARD: one request outstanding, response to be dropped.
- Request: imem_req_valid = !rst && state==F_RUN && count<2 && !PCsrc. imem_addr=pc.
  - On accept (valid&ready): req_pc<=pc, pc<=pc+PC_STEP (mod 2^32), state<=F_WAIT.
  - Only one request is ever outstanding.
- Response in F_WAIT: push {imem_rsp_data, req_pc} into the queue; state<=F_RUN. Overflow is impossible: an issue requires count<=1, and count cannot grow until the response arrives.
- Response in F_DISCARD: data dropped; state<=F_RUN.
- Response in F_RUN: ignored. This covers stale responses after a mid-operation reset.
- Pop: instr_valid=(count>0); head driven on instruction/instr_pc. Pop on instr_valid&&instr_ready. Push and pop in the same cycle leave count unchanged.
- Redirect (PCsrc=1), highest priority over push/pop/issue:
  - pc<=branch_pc+ImmOp, 32-bit wrap, no alignment check.
  - Queue flushed (count<=0), so instr_valid=0 next cycle.
  - A response arriving in the same cycle is dropped.
  - State: F_WAIT with no same-cycle response -> F_DISCARD; F_DISCARD stays F_DISCARD unless a response arrives (then F_RUN); F_RUN stays F_RUN.
- Latency:
  - Request accepted in cycle N with response in N+1 -> instr_valid in N+2.
  - Next request is issued in N+2.
  - Peak throughput is one instruction per 2 cycles with 1-cycle memory.
- Back-pressure: with count==2, no requests are issued until a pop.
- Redirect during back-pressure: flush, and fetching from the target resumes next cycle.

Decomposition:
- Package fetch_pkg:
  - DATA_WIDTH and RESET_PC constants
  - fetch_state_t enum {F_RUN, F_WAIT, F_DISCARD}
  - fetch_entry_t struct {instr, pc}
- Sub-module fetch_fifo2: 2-entry fetch_entry_t queue with push, pop, synchronous flush, count output and head output. Flush has priority over push.

Test Plan:
- Reset, then ready=1 and 1-cycle response 0x00500093 -> req at addr 0x0, instr_valid at cycle 2 with instruction=0x00500093, instr_pc=0x0; next request addr 0x4.
- instr_ready=0, memory always ready -> exactly two entries queued (pc 0x0, 0x4); imem_req_valid stays 0 until one pop, then addr 0x8 issued.
- Outstanding request, PCsrc=1 with branch_pc=0x10, ImmOp=0xFFFFFFF8, response arrives 2 cycles later -> response dropped, count=0, next request addr 0x8.
- PCsrc=1 in same cycle as imem_rsp_valid in F_WAIT -> response not queued, state F_RUN, next request addr branch_pc+ImmOp.
- Wrap: branch_pc=0xFFFFFFFC, ImmOp=0x8 -> next imem_addr 0x00000004.
- rst asserted while in F_WAIT, stale response returns after reset -> ignored; first post-reset request addr RESET_PC; instr_valid stays 0 until its response.
